// File: rtl/int_to_float_scheduler_pkg.sv
// Shared constants, float-format helpers and the conversion tag type for the
// int-to-float scheduler.
package int_to_float_pkg;

  localparam int CVT_LATENCY = 4;
  localparam int MAX_ID_W    = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  function automatic int float_size(input int exp_w, input int mant_w);
    return 1 + exp_w + mant_w;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/int_to_float_scheduler_arb.sv
// Combinational round-robin arbiter: the first asserted request at or above
// the pointer (wrapping) wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_any,
  output logic [ID_W-1:0]    o_grant_id
);

  int w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_any = 1'b0;
    o_grant_id  = '0;
    w_idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = int'(i_ptr) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!o_grant_any && i_req[w_idx]) begin
        o_grant_any = 1'b1;
        o_grant_id  = ID_W'(w_idx);
      end
    end
    if (o_grant_any) o_grant[o_grant_id] = 1'b1;
  end

endmodule

// File: rtl/int_to_float_scheduler_cvt.sv
// Four-stage signed integer to float converter, round-to-nearest-even.
// Stages are deliberately not reset; the scheduler's tag pipe qualifies them.
module int_to_float_cvt import int_to_float_pkg::*; #(
  parameter  int INT_SIZE      = 32,
  parameter  int MANTISSA_SIZE = 23,
  parameter  int EXPONENT_SIZE = 8,
  localparam int FLOAT_SIZE    = float_size(EXPONENT_SIZE, MANTISSA_SIZE)
) (
  input  logic                  clk,
  input  logic [INT_SIZE-1:0]   i_int,
  output logic [FLOAT_SIZE-1:0] o_float
);

  localparam int POS_W = $clog2(INT_SIZE);
  localparam int LOW_W = INT_SIZE - 1 - MANTISSA_SIZE;
  localparam int BIAS  = exp_bias(EXPONENT_SIZE);
  localparam logic [INT_SIZE-1:0] STICKY_MASK = INT_SIZE'((64'd1 << (LOW_W - 1)) - 64'd1);

  logic                     r1_sign;
  logic [INT_SIZE-1:0]      r1_mag;
  logic [POS_W-1:0]         w_msb;
  logic [INT_SIZE-1:0]      w_norm;
  logic                     r2_sign;
  logic                     r2_zero;
  logic [POS_W-1:0]         r2_exp;
  logic [INT_SIZE-2:0]      r2_norm;
  logic [MANTISSA_SIZE-1:0] w_mant;
  logic                     w_guard;
  logic                     w_sticky;
  logic                     w_round;
  logic [MANTISSA_SIZE:0]   w_mant_r;
  logic                     r3_sign;
  logic                     r3_zero;
  logic [EXPONENT_SIZE-1:0] r3_exp;
  logic [MANTISSA_SIZE-1:0] r3_mant;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < INT_SIZE; i++) begin
      if (r1_mag[i]) w_msb = POS_W'(i);
    end
    w_norm = r1_mag << (POS_W'(INT_SIZE - 1) - w_msb);
  end

  // Normalised leading one is implicit; the bits below the kept mantissa
  // split into the guard bit and a sticky OR of the rest.
  always_comb begin
    w_mant   = r2_norm[INT_SIZE-2 -: MANTISSA_SIZE];
    w_guard  = r2_norm[LOW_W-1];
    w_sticky = |({1'b0, r2_norm} & STICKY_MASK);
    w_round  = w_guard & (w_sticky | w_mant[0]);
    w_mant_r = {1'b0, w_mant} + {{MANTISSA_SIZE{1'b0}}, w_round};
  end

  always_ff @(posedge clk) begin
    r1_sign <= i_int[INT_SIZE-1];
    r1_mag  <= i_int[INT_SIZE-1] ? -i_int : i_int;
    r2_sign <= r1_sign;
    r2_zero <= ~w_norm[INT_SIZE-1];
    r2_exp  <= w_msb;
    r2_norm <= w_norm[INT_SIZE-2:0];
    r3_sign <= r2_sign;
    r3_zero <= r2_zero;
    r3_mant <= w_mant_r[MANTISSA_SIZE-1:0];
    r3_exp  <= EXPONENT_SIZE'(BIAS) + EXPONENT_SIZE'(r2_exp)
             + EXPONENT_SIZE'(w_mant_r[MANTISSA_SIZE]);
    o_float <= r3_zero ? '0 : {r3_sign, r3_exp, r3_mant};
  end

endmodule

// File: rtl/int_to_float_scheduler.sv
// Round-robin sharing of one pipelined int-to-float converter between
// NUM_REQ requesters, with a requester-ID tag pipe matched to its latency.
module int_to_float_scheduler import int_to_float_pkg::*; #(
  parameter  int NUM_REQ       = 4,
  parameter  int MANTISSA_SIZE = 23,
  parameter  int EXPONENT_SIZE = 8,
  parameter  int INT_SIZE      = 32,
  parameter  int LATENCY       = CVT_LATENCY,
  localparam int ID_SIZE       = $clog2(NUM_REQ),
  localparam int FLOAT_SIZE    = float_size(EXPONENT_SIZE, MANTISSA_SIZE),
  localparam int IF_W          = $clog2(LATENCY + 1)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*INT_SIZE-1:0] req_data,
  output logic                        rsp_valid,
  output logic [ID_SIZE-1:0]          rsp_id,
  output logic [FLOAT_SIZE-1:0]       rsp_data,
  output logic                        busy,
  output logic [IF_W-1:0]             in_flight
);

  logic [ID_SIZE-1:0]    r_ptr;
  logic [LATENCY-1:0]    r_tag_vld;
  logic [ID_SIZE-1:0]    r_tag_id [LATENCY];
  logic [IF_W-1:0]       r_in_flight;
  logic                  r_busy;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_grant_any;
  logic [ID_SIZE-1:0]    w_grant_id;
  logic [INT_SIZE-1:0]   w_cvt_in;
  logic [FLOAT_SIZE-1:0] w_cvt_out;
  logic [IF_W-1:0]       w_if_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_any (w_grant_any),
    .o_grant_id  (w_grant_id)
  );

  always_comb begin
    w_cvt_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_cvt_in = req_data[i*INT_SIZE +: INT_SIZE];
    end
  end

  int_to_float_cvt #(
    .INT_SIZE      (INT_SIZE),
    .MANTISSA_SIZE (MANTISSA_SIZE),
    .EXPONENT_SIZE (EXPONENT_SIZE)
  ) u_cvt (
    .clk     (clk),
    .i_int   (w_cvt_in),
    .o_float (w_cvt_out)
  );

  // Occupancy after this edge: the new stage-0 entry plus everything that
  // does not fall off the end of the pipe.
  always_comb begin
    w_if_next = IF_W'(w_grant_any);
    for (int k = 0; k < LATENCY - 1; k++) begin
      w_if_next = w_if_next + IF_W'(r_tag_vld[k]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= '0;
      r_tag_vld   <= '0;
      r_tag_id    <= '{default: '0};
      r_in_flight <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_tag_vld   <= {r_tag_vld[LATENCY-2:0], w_grant_any};
      r_tag_id[0] <= w_grant_id;
      for (int k = 1; k < LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
      r_in_flight <= w_if_next;
      r_busy      <= (w_if_next != '0);
      if (w_grant_any) begin
        r_ptr <= (w_grant_id == ID_SIZE'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_SIZE'(1);
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_tag_vld[LATENCY-1];
  assign rsp_id    = r_tag_id[LATENCY-1];
  assign rsp_data  = rsp_valid ? w_cvt_out : '0;
  assign busy      = r_busy;
  assign in_flight = r_in_flight;

endmodule

// File: tb/tb_int_to_float_scheduler.sv
// Scoreboard bench: a reference arbiter/float model pushes expected results
// at acceptance; an independent monitor pops them when rsp_valid appears.
module tb_int_to_float_scheduler;

  localparam int N = 4;
  localparam int L = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_data = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          busy;
  logic [2:0]    in_flight;

  int_to_float_scheduler dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .in_flight (in_flight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic [31:0] f;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp_v);
    end
  endtask

  // Single-precision value of an integer from first principles: find the
  // exponent, scale to 24 significant bits, round half to even.
  function automatic logic [31:0] ref_float(input logic signed [31:0] x);
    longint m, q, r, half;
    int     e;
    bit     s;
    if (x == 0) return 32'h0;
    s = (x < 0);
    m = s ? -longint'(x) : longint'(x);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      q    = m >> (e - 23);
      r    = m - (q << (e - 23));
      half = longint'(1) << (e - 24);
      if (r > half || (r == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_int();
    logic signed [31:0] v;
    v = $urandom;
    v = v >>> $urandom_range(0, 31);
    if (v == 32'sh8000_0000) v = 0;
    return v;
  endfunction

  // Reference model: arbitration, occupancy and starvation bound.
  initial begin : model
    int ptr;
    int g;
    int hist[L];
    int waitc[N];
    int exp_if;
    ptr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ptr = 0;
        foreach (hist[k]) hist[k] = 0;
        foreach (waitc[k]) waitc[k] = 0;
        chk("in_flight_rst", 64'(in_flight), 64'd0);
        chk("busy_rst", 64'(busy), 64'd0);
      end else begin
        exp_if = 0;
        foreach (hist[k]) exp_if += hist[k];
        chk("in_flight", 64'(in_flight), 64'(exp_if));
        chk("busy", 64'(busy), 64'(exp_if != 0));
        g = -1;
        for (int off = 0; off < N; off++) begin
          if (g < 0 && req_valid[(ptr + off) % N]) g = (ptr + off) % N;
        end
        chk("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
          sbq.push_back('{g, ref_float(req_data[g*32 +: 32]), cyc});
          ptr = (g + 1) % N;
        end
        for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = (g >= 0) ? 1 : 0;
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && g != i) waitc[i]++;
          else waitc[i] = 0;
          if (waitc[i] >= N) begin
            n_cmp++;
            n_bad++;
            $display("FAIL starvation: req %0d waited %0d cycles, limit %0d", i, waitc[i], N - 1);
            waitc[i] = 0;
          end
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sbq.delete();
        chk("rsp_valid_rst", 64'(rsp_valid), 64'd0);
        chk("rsp_id_rst", 64'(rsp_id), 64'd0);
        chk("rsp_data_rst", 64'(rsp_data), 64'd0);
      end else if (rsp_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp @cyc %0d: got id %0d data %h, want none", cyc, rsp_id, rsp_data);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_data", 64'(rsp_data), 64'(e.f));
          chk("latency", 64'(cyc - e.cyc), 64'(L));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a fixed set of requests, dropping each once it is accepted.
  task automatic run_hold(input logic [N-1:0] v, input logic [31:0] d0, d1, d2, d3);
    logic [N-1:0] acc;
    req_data  = {d3, d2, d1, d0};
    req_valid = v;
    for (int c = 0; c < 4 * N && req_valid != '0; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~acc;
    end
    n_cmp++;
    if (req_valid != '0) begin
      n_bad++;
      $display("FAIL hold_timeout: got pending %b, want 0", req_valid);
    end
    req_valid = '0;
  endtask

  // Keep the masked requesters valid; each acceptance loads the next value.
  task automatic stream(input logic [N-1:0] mask, input int ncyc, inout int nextv);
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req_data[i*32 +: 32] = 32'(nextv);
        nextv++;
      end
    end
    req_valid = mask;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_data[i*32 +: 32] = 32'(nextv);
          nextv++;
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  initial begin : main
    int v;
    logic [N-1:0] acc;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    idle(2);

    run_hold(4'b0001, 32'd1, 32'd0, 32'd0, 32'd0);
    idle(6);
    run_hold(4'b1111, 32'd100, -32'sd2, 32'd0, 32'd7);
    idle(6);

    v = 1000;
    stream(4'b0101, 8, v);
    idle(6);
    v = 1;
    stream(4'b1000, 8, v);
    idle(6);

    // Reset lands mid-cycle while three conversions are in the pipe.
    v = 50;
    req_data[0 +: 32]  = 32'd11;
    req_data[32 +: 32] = 32'd22;
    req_data[64 +: 32] = 32'd33;
    req_valid = 4'b0111;
    tick();
    tick();
    #2;
    resetn    = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    resetn = 1'b1;
    idle(10);
    run_hold(4'b1010, 32'd0, 32'd5, 32'd0, -32'sd9);
    idle(6);

    // Requester 1 withdraws while requester 0 holds the grant.
    req_data  = {32'd0, 32'd0, 32'd77, 32'd66};
    req_valid = 4'b0011;
    tick();
    req_valid = '0;
    idle(8);

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            req_valid[i] = 1'b1;
            req_data[i*32 +: 32] = rand_int();
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;

    for (int c = 0; c < 20 && sbq.size() != 0; c++) tick();
    chk("drain", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_to_float_scheduler.md
Name: int_to_float_scheduler

Overview:
- Shares one pipelined signed-int-to-float converter (IntToFloat, fixed latency 4, one conversion per clock, no stall) between NUM_REQ requesters.
- Round-robin arbitration selects at most one request per cycle and feeds it to the converter.
- A requester-ID tag travels alongside each conversion; results come back on a single tagged, non-stallable response bus.
- Sits between integer producers (e.g. vertex/attribute fetch) and float consumers in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MANTISSA_SIZE, 23, float mantissa width, passed to the converter.
- EXPONENT_SIZE, 8, float exponent width, passed to the converter.
- INT_SIZE, 32, signed integer width; must be at least MANTISSA_SIZE+2.
- LATENCY, 4, converter latency in clocks; must equal the converter's actual latency.
- ID_SIZE, $clog2(NUM_REQ), requester ID width (localparam).
- FLOAT_SIZE, 1+EXPONENT_SIZE+MANTISSA_SIZE (localparam).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_data  in  NUM_REQ*INT_SIZE  packed signed integers; requester i occupies [i*INT_SIZE +: INT_SIZE].
- rsp_valid  out  1  result valid pulse.
- rsp_id  out  ID_SIZE  requester index that owns the result.
- rsp_data  out  FLOAT_SIZE  converted float.
- busy  out  1  high while any conversion is in flight.
- in_flight  out  $clog2(LATENCY+1)  number of conversions in the pipe.

Behaviour:
- Reset (async assert, sync deassert expected upstream): rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, in_flight=0, all tag valids=0, RR pointer=0 (requester 0 highest priority).
- req_ready is combinational from req_valid and the RR pointer; req_ready[i]=1 only if req_valid[i]=1. Handshake: transfer on req_valid[i]&&req_ready[i].
- Requesters hold req_valid and req_data stable until accepted. Deasserting req_valid before acceptance is allowed (withdraws the request).
- Arbitration: search from pointer p upward, wrapping modulo NUM_REQ; the first asserted valid wins. After a grant to g, p <= (g+1) mod NUM_REQ. With no grant, p is unchanged.
- Data path: the granted req_data slice is muxed combinationally to the converter input. With no grant, the input is driven to 0 and the tag valid to 0.
- Tag pipe: LATENCY stages of {valid, id}, shifted every clock. Stage 0 loads {grant_any, grant_id} at the accept edge.
- Output: rsp_valid/rsp_id come from the last tag stage; rsp_data comes straight from the converter output. Accept in cycle c yields rsp_valid in cycle c+LATENCY. Throughput is 1 per clock.
- No response backpressure. Consumers must take the result in the rsp_valid cycle. rsp_data is don't-care when rsp_valid=0.
- in_flight = popcount of tag valids; busy = (in_flight!=0). Both are registered alongside the tag pipe, so there is no extra lag.
- Starvation bound: a continuously asserted requester is granted within NUM_REQ cycles.
- Reset mid-operation: tag valids clear immediately, so in-flight results are discarded and no rsp_valid appears after reset. Converter stages are not reset and their contents are ignored.
- Simultaneous all-valid requests: grants rotate 0,1,..,NUM_REQ-1,0...
- Boundary cases: pointer wraps at NUM_REQ-1 → 0. Single requester streaming alone is granted every cycle.
- Conversion results follow converter semantics: 0 → all-zero float; minimum negative integer is not supported.

Decomposition:
- Shared package int_to_float_pkg: LATENCY constant (4), FLOAT_SIZE/bias helper functions, tag struct {valid, id}.
- Sub-module rr_arbiter (NUM_REQ): request vector and pointer in; one-hot grant, grant_any, binary grant_id out; purely combinational.
- Pointer register, tag pipe, and the converter instance live in the top block.

Test Plan:
- Single requester: req 0 sends 1 at cycle 0 → req_ready[0]=1 at cycle 0; rsp_valid, rsp_id=0, rsp_data=0x3F800000 at cycle 4; busy high cycles 1–4.
- All four requesters valid with data 100, -2, 0, 7 held → grants in order 0,1,2,3 on cycles 0–3; responses at cycles 4–7 are 0x42C80000 (id0), 0xC0000000 (id1), 0x00000000 (id2), 0x40E00000 (id3).
- Fairness: req 0 and req 2 continuously valid → grants alternate 0,2,0,2; req 2 is never denied two cycles running.
- Back-to-back from one requester: 8 consecutive values 1..8 from req 3 → 8 consecutive rsp_valid cycles; in_flight reads 4 in steady state; data matches the reference float model.
- Reset mid-flight: issue 3 requests, assert resetn=0 at cycle 2 → rsp_valid stays 0 through cycle 10; pointer returns to 0; the first post-reset grant goes to the lowest valid index.
- Withdrawal: req 1 drops req_valid while req 0 is granted → no grant or response ever appears for id 1.
